// File: rtl/io_ccff_pkg.sv
// Shared definitions for IO configuration-chain memory segments.
package io_ccff_pkg;

    localparam int unsigned IO_PO_MODE_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } ccff_state_e;

    // Flat constants so state registers can stay plain logic vectors.
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_FILL  = FILL;
    localparam logic [1:0] ST_READY = READY;

    // XOR-reduce of a word zero-extended to 32 bits; segments are <= 32 bits wide.
    function automatic logic parity32(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/io_ccff_shift_reg.sv
// Serial configuration shift register with enable; bit 0 is the head end.
module io_ccff_shift_reg #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    output logic [0:WIDTH-1] q,
    output logic             tail
);

    // Shift toward the tail end while enabled, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= {din, q[0:WIDTH-2]};
        end
    end

    // Tail is the last flop of the chain, so it is registered.
    assign tail = q[WIDTH-1];

endmodule

// File: rtl/io_po_mode_ccff_loader.sv
// Config-chain segment loading the IO output-pad scan-FF mode word into a
// shadow register on a parity-checked commit.
module io_po_mode_ccff_loader
    import io_ccff_pkg::*;
#(
    parameter int unsigned     WIDTH      = IO_PO_MODE_W,
    parameter logic [0:WIDTH-1] MODE_RESET = '0
) (
    input  logic             prog_clk,
    input  logic             pReset,
    input  logic             ccff_head,
    input  logic             ccff_shift_en,
    input  logic             ccff_commit,
    input  logic             ccff_parity,
    output logic             ccff_tail,
    output logic [0:WIDTH-1] mem_out,
    output logic [0:WIDTH-1] mem_outb,
    output logic             cfg_valid,
    output logic             cfg_err
);

    localparam int unsigned        CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(WIDTH);

    logic [0:WIDTH-1] shift_q;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [0:WIDTH-1] mem_d;
    logic             valid_d;
    logic             err_d;
    logic             parity_bad_c;

    io_ccff_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk  (prog_clk),
        .rst  (pReset),
        .en   (ccff_shift_en),
        .din  (ccff_head),
        .q    (shift_q),
        .tail (ccff_tail)
    );

    assign parity_bad_c = parity32(32'(shift_q)) ^ ccff_parity;

    // State, counter and shadow registers; mem_out only moves on a good commit.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mem_out   <= MODE_RESET;
            mem_outb  <= ~MODE_RESET;
            cfg_valid <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_out   <= mem_d;
            mem_outb  <= ~mem_d;
            cfg_valid <= valid_d;
            cfg_err   <= err_d;
        end
    end

    // Next-state: count shifts, accept a commit only when full and not shifting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_out;
        valid_d = cfg_valid;
        err_d   = cfg_err;

        if (ccff_shift_en) begin
            // Extra bits beyond WIDTH pass through the chain; the count saturates.
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            state_d = (cnt_d == CNT_MAX) ? ST_READY : ST_FILL;
            if (ccff_commit) begin
                err_d = 1'b1;
            end
        end else if (ccff_commit) begin
            if (state_q == ST_READY) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                if (parity_bad_c) begin
                    err_d = 1'b1;
                end else begin
                    mem_d   = shift_q;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                end
            end else begin
                // Short load: keep filling, just flag the attempt.
                err_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_po_mode_ccff_loader.sv
// Directed bench for io_po_mode_ccff_loader: vector table plus corner sequences.
module tb_io_po_mode_ccff_loader;

    logic       prog_clk = 1'b0;
    logic       pReset = 1'b1;
    logic       ccff_head = 1'b0;
    logic       ccff_shift_en = 1'b0;
    logic       ccff_commit = 1'b0;
    logic       ccff_parity = 1'b0;
    logic       ccff_tail;
    logic [0:6] mem_out;
    logic [0:6] mem_outb;
    logic       cfg_valid;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;

    io_po_mode_ccff_loader dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_commit   (ccff_commit),
        .ccff_parity   (ccff_parity),
        .ccff_tail     (ccff_tail),
        .mem_out       (mem_out),
        .mem_outb      (mem_outb),
        .cfg_valid     (cfg_valid),
        .cfg_err       (cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       head;
        logic       commit;
        logic       par;
        logic [0:6] mem;
        logic       tail;
        logic       valid;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic rst, input logic en, input logic head,
                               input logic commit, input logic par,
                               input logic [0:6] mem, input logic tail,
                               input logic valid, input logic err);
        vec_t r;
        r.rst = rst; r.en = en; r.head = head; r.commit = commit; r.par = par;
        r.mem = mem; r.tail = tail; r.valid = valid; r.err = err;
        return r;
    endfunction

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [0:6] mem, input logic tail,
                             input logic valid, input logic err);
        logic [0:6] memb;
        memb = ~mem;
        check({tag, "_mem"},   7'(mem_out),   7'(mem));
        check({tag, "_memb"},  7'(mem_outb),  7'(memb));
        check({tag, "_tail"},  7'(ccff_tail), 7'(tail));
        check({tag, "_valid"}, 7'(cfg_valid), 7'(valid));
        check({tag, "_err"},   7'(cfg_err),   7'(err));
    endtask

    task automatic drive(input logic en, input logic head, input logic commit, input logic par);
        ccff_shift_en = en;
        ccff_head     = head;
        ccff_commit   = commit;
        ccff_parity   = par;
    endtask

    // One clock with the given inputs, leaving sampling 1 time unit after the edge.
    task automatic step(input logic en, input logic head, input logic commit, input logic par);
        drive(en, head, commit, par);
        @(posedge prog_clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Words are pushed with index 6 first, so after 7 shifts shift[i] == word[i].
    localparam logic [0:6] W_A = 7'b1011001; // even parity
    localparam logic [0:6] W_X = 7'b0110100; // odd parity

    initial begin
        logic [13:0] pat;
        logic        pushed[$];
        logic [0:6]  exp_w;
        logic [0:6]  wa;
        logic        b;
        int          n;

        // Reset, normal load of W_A: push order 1,0,0,1,1,0,1
        tbl.push_back(v(1,0,0,0,0, 7'b0000000, 0,0,0));
        tbl.push_back(v(0,1,1,0,0, 7'b0000000, 0,0,0));
        tbl.push_back(v(0,1,0,0,0, 7'b0000000, 0,0,0));
        tbl.push_back(v(0,1,0,0,0, 7'b0000000, 0,0,0));
        tbl.push_back(v(0,1,1,0,0, 7'b0000000, 0,0,0));
        tbl.push_back(v(0,1,1,0,0, 7'b0000000, 0,0,0));
        tbl.push_back(v(0,1,0,0,0, 7'b0000000, 0,0,0));
        tbl.push_back(v(0,1,1,0,0, 7'b0000000, 1,0,0));
        tbl.push_back(v(0,0,0,1,0, W_A,        1,1,0));
        // Short load of W_X (push order 0,0,1,0 | 1,1,0); tail drains the old W_A
        tbl.push_back(v(0,1,0,0,0, W_A, 0,1,0));
        tbl.push_back(v(0,1,0,0,0, W_A, 0,1,0));
        tbl.push_back(v(0,1,1,0,0, W_A, 1,1,0));
        tbl.push_back(v(0,1,0,0,0, W_A, 1,1,0));
        tbl.push_back(v(0,0,0,1,1, W_A, 1,1,1));
        tbl.push_back(v(0,1,1,0,0, W_A, 0,1,1));
        tbl.push_back(v(0,1,1,0,0, W_A, 1,1,1));
        tbl.push_back(v(0,1,0,0,0, W_A, 0,1,1));
        tbl.push_back(v(0,0,0,1,1, W_X, 0,1,0));
        // Reload W_A with wrong parity bit: shadow keeps W_X
        tbl.push_back(v(0,1,1,0,0, W_X, 0,1,0));
        tbl.push_back(v(0,1,0,0,0, W_X, 1,1,0));
        tbl.push_back(v(0,1,0,0,0, W_X, 0,1,0));
        tbl.push_back(v(0,1,1,0,0, W_X, 1,1,0));
        tbl.push_back(v(0,1,1,0,0, W_X, 1,1,0));
        tbl.push_back(v(0,1,0,0,0, W_X, 0,1,0));
        tbl.push_back(v(0,1,1,0,0, W_X, 1,1,0));
        tbl.push_back(v(0,0,0,1,1, W_X, 1,1,1));

        #2;
        for (int i = 0; i < tbl.size(); i++) begin
            pReset = tbl[i].rst;
            step(tbl[i].en, tbl[i].head, tbl[i].commit, tbl[i].par);
            check_all($sformatf("vec%0d", i), tbl[i].mem, tbl[i].tail, tbl[i].valid, tbl[i].err);
        end

        // Pass-through: 14 bits from a clean register, tail delayed by 7 shifts
        pReset = 1'b1;
        step(0, 0, 0, 0);
        pReset = 1'b0;
        pat = 14'b10110011100101;
        for (int k = 0; k < 14; k++) begin
            b = pat[13-k];
            pushed.push_back(b);
            step(1, b, 0, 0);
            check($sformatf("thru%0d_tail", k+1), 7'(ccff_tail),
                  7'((k >= 6) ? pushed[k-6] : 1'b0));
        end

        // Collision: commit during a shift is rejected but the bit still moves
        pushed.push_back(1'b1);
        step(1, 1, 1, 0);
        check_all("collide", 7'b0000000, pushed[8], 1'b0, 1'b1);

        // Commit the last 7 bits with their true parity
        n = pushed.size();
        for (int i = 0; i < 7; i++) exp_w[i] = pushed[n-1-i];
        step(0, 0, 1, ^exp_w);
        check_all("after_collide", exp_w, exp_w[6], 1'b1, 1'b0);

        // Mid-shift asynchronous reset after 3 shifts
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        #2;
        pReset = 1'b1;
        #1;
        check_all("async_rst", 7'b0000000, 1'b0, 1'b0, 1'b0);
        @(posedge prog_clk);
        #1;
        pReset = 1'b0;

        // Six bits alone are still a short load, so the count really restarted
        wa = W_A;
        for (int i = 6; i >= 1; i--) step(1, wa[i], 0, 0);
        check("rst_tail6", 7'(ccff_tail), 7'(1'b0));
        step(0, 0, 1, 0);
        check_all("rst_short", 7'b0000000, 1'b0, 1'b0, 1'b1);
        step(1, wa[0], 0, 0);
        check("rst_tail7", 7'(ccff_tail), 7'(wa[6]));
        step(0, 0, 1, 0);
        check_all("rst_reload", W_A, wa[6], 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
